// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / fetch-sequencing stage.
package fetch_pkg;

    localparam int PC_W  = 10;
    localparam int IDX_W = 5;
    localparam int CNT_W = 16;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: hold on halt/stall, jump to the LUT target on a taken
// branch, otherwise step by one. Outside RUN the PC simply holds; loading the
// start address is handled by the sequencer in the top level.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int PC_W = fetch_pkg::PC_W
) (
    input  fetch_state_t    state,
    input  logic            halt_req,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] lut_target,
    output logic [PC_W-1:0] next_pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Select the next PC by priority halt > stall > taken branch > increment.
    always_comb begin
        next_pc = pc;
        case (state)
            RUN: begin
                if (halt_req) begin
                    next_pc = pc;
                end else if (stall) begin
                    next_pc = pc;
                end else if (branch_taken) begin
                    next_pc = lut_target;
                end else begin
                    next_pc = pc + PC_ONE;
                end
            end
            IDLE, HALTED: begin
                next_pc = pc;
            end
            default: begin
                next_pc = pc;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-sequencing stage: start/halt sequencing, branch
// redirection through an external combinational target LUT, and a saturating
// count of cycles spent running.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = fetch_pkg::PC_W,
    parameter int              IDX_W    = fetch_pkg::IDX_W,
    parameter int              CNT_W    = fetch_pkg::CNT_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic              BranchCond,
    input  logic [IDX_W-1:0]  BranchIdx,
    input  logic              HaltReq,
    output logic [IDX_W-1:0]  LutAddr,
    input  logic [PC_W-1:0]   LutTarget,
    output logic [PC_W-1:0]   PC,
    output logic              Running,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCount
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  next_pc_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             branch_taken_s;

    assign LutAddr        = BranchIdx;
    assign branch_taken_s = BranchEn & BranchCond;

    assign PC         = pc_q;
    assign Running    = running_q;
    assign Done       = done_q;
    assign CycleCount = cnt_q;

    fetch_next_pc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .state        (state_q),
        .halt_req     (HaltReq),
        .stall        (Stall),
        .branch_taken (branch_taken_s),
        .pc           (pc_q),
        .lut_target   (LutTarget),
        .next_pc      (next_pc_s)
    );

    // Sequencer: start/halt transitions, start-address load and saturating cycle count.
    always_comb begin
        state_d = state_q;
        pc_d    = next_pc_s;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = StartAddr;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = state_q;
                    pc_d    = next_pc_s;
                    cnt_d   = cnt_q;
                end
            end
            RUN: begin
                // Every RUN cycle counts, stall and halt cycles included.
                if (cnt_q == CNT_MAX) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (HaltReq) begin
                    state_d = HALTED;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = pc_q;
                cnt_d   = cnt_q;
            end
        endcase
        // Status flags follow the state being registered, so they depend on state only.
        running_d = (state_d == RUN);
        done_d    = (state_d == HALTED);
    end

    // State, PC, counter and status registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= CNT_ZERO;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

endmodule
